// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and instruction-fetch sequencer. A four-state FSM
// (IDLE -> FETCH -> EXEC -> FETCH ... or HALT) issues one instruction-memory
// read per instruction. In EXEC it selects the next PC, in priority order:
//   1. JALR target with the LSB cleared
//   2. branch/JAL target
//   3. pc + 4
// If the selected next PC is not word-aligned, the unit redirects to TRAP_VEC
// instead.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   pc_gen_out   : take branch/JAL target (EXEC only)
//   jalr_sel     : take JALR target, overrides pc_gen_out (EXEC only)
//   target       : branch/JAL target address
//   jalr_target  : JALR target before LSB clear
//   stall        : hold current instruction in EXEC
//   halt_req     : stop fetching after current instruction
//   imem_ack     : instruction memory read complete (FETCH only)
//   imem_req     : instruction memory read request
//   imem_addr    : read address, equals pc
//   pc           : current program counter
//   pc_plus4     : pc + 4, modulo 2^32
//   instr_valid  : fetched instruction valid (EXEC)
//   misalign     : one-cycle pulse after a misaligned transfer
//   halted       : unit in HALT
//
// Every output is a register or a decode of state/pc, so no input has a
// combinational path to an output.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_gen_out,
  input  logic        jalr_sel,
  input  logic [31:0] target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_misalign;
  logic        w_misalign_next;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jalr_pc;
  logic [31:0] w_sel_pc;

  assign w_pc_plus4 = r_pc + 32'd4;
  // Masking keeps every bit of jalr_target in use while clearing bit 0.
  assign w_jalr_pc  = jalr_target & 32'hFFFF_FFFE;
  assign w_sel_pc   = jalr_sel   ? w_jalr_pc :
                      pc_gen_out ? target    :
                                   w_pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_misalign <= w_misalign_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_misalign_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        // Stall dominates halt and redirects: the instruction stays put.
        if (!stall) begin
          if (halt_req) begin
            w_state_next = S_HALT;
          end else if (w_sel_pc[1:0] != 2'b00) begin
            w_state_next    = S_FETCH;
            w_pc_next       = TRAP_VEC;
            w_misalign_next = 1'b1;
          end else begin
            w_state_next = S_FETCH;
            w_pc_next    = w_sel_pc;
          end
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr_valid = (r_state == S_EXEC);
  assign misalign    = r_misalign;
  assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed stimulus for pc_fetch_unit. A behavioural model tracks which phase
// the unit must be in and which PC it must hold; a compare process checks all
// outputs against it on every falling edge after the first reset. The
// directed sequence also checks hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        pc_gen_out;
  logic        jalr_sel;
  logic [31:0] target;
  logic [31:0] jalr_target;
  logic        stall;
  logic        halt_req;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .RESET_PC(RESET_PC),
    .TRAP_VEC(TRAP_VEC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_gen_out  (pc_gen_out),
    .jalr_sel    (jalr_sel),
    .target      (target),
    .jalr_target (jalr_target),
    .stall       (stall),
    .halt_req    (halt_req),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .misalign    (misalign),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Phase of the instruction life cycle the unit must be in.
  localparam int P_BOOT = 10, P_READ = 20, P_RUN = 30, P_STOP = 40;
  int          m_phase = P_BOOT;
  logic [31:0] m_pc    = 32'h0;
  logic        m_trap  = 1'b0;
  bit          m_live  = 1'b0;

  always @(posedge clk) begin
    logic [31:0] dest;
    if (rst) begin
      m_phase = P_BOOT;
      m_pc    = RESET_PC;
      m_trap  = 1'b0;
      m_live  = 1'b1;
    end else begin
      m_trap = 1'b0;
      if (m_phase == P_BOOT) begin
        m_phase = P_READ;
      end else if (m_phase == P_READ) begin
        if (imem_ack) m_phase = P_RUN;
      end else if (m_phase == P_RUN && !stall) begin
        if (halt_req) begin
          m_phase = P_STOP;
        end else begin
          if (jalr_sel)        dest = jalr_target - (jalr_target % 2);
          else if (pc_gen_out) dest = target;
          else                 dest = m_pc + 32'd4;
          if (dest % 4 != 0) begin
            m_pc   = TRAP_VEC;
            m_trap = 1'b1;
          end else begin
            m_pc = dest;
          end
          m_phase = P_READ;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_imem_req",    {31'b0, imem_req},    {31'b0, m_phase == P_READ});
      chk("m_instr_valid", {31'b0, instr_valid}, {31'b0, m_phase == P_RUN});
      chk("m_halted",      {31'b0, halted},      {31'b0, m_phase == P_STOP});
      chk("m_misalign",    {31'b0, misalign},    {31'b0, m_trap});
      chk("m_pc",          pc,                   m_pc);
      chk("m_imem_addr",   imem_addr,            m_pc);
      chk("m_pc_plus4",    pc_plus4,             m_pc + 32'd4);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic clear_ctl();
    pc_gen_out  = 1'b0;
    jalr_sel    = 1'b0;
    target      = 32'h0;
    jalr_target = 32'h0;
    stall       = 1'b0;
    halt_req    = 1'b0;
  endtask

  // Advance to the next falling edge where an instruction is in EXEC.
  task automatic wait_exec(input string name);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for instr_valid", name);
    end
  endtask

  initial begin
    int req_cnt;
    int val_cnt;
    rst      = 1'b1;
    imem_ack = 1'b0;
    clear_ctl();

    // Reset state
    @(negedge clk);
    chk("rst_pc",          pc,                   RESET_PC);
    chk("rst_imem_req",    {31'b0, imem_req},    32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_halted",      {31'b0, halted},      32'h0);
    rst      = 1'b0;
    imem_ack = 1'b1;

    // Sequential fetch: 0x0, 0x4, 0x8, 0xC, 0x10
    wait_exec("seq0");  chk("seq_pc0", pc, 32'h0);
    @(negedge clk);     chk("seq_gap_valid", {31'b0, instr_valid}, 32'h0);
    wait_exec("seq1");  chk("seq_pc1", pc, 32'h4);
    wait_exec("seq2");  chk("seq_pc2", pc, 32'h8);
    wait_exec("seq3");
    wait_exec("seq4");  chk("seq_pc4", pc, 32'h10);

    // Branch to 0x40, then JALR 0x81 overriding branch -> 0x80
    pc_gen_out = 1'b1; target = 32'h40;
    @(negedge clk);     chk("br_addr", imem_addr, 32'h40);
    clear_ctl();
    wait_exec("br");
    pc_gen_out = 1'b1; target = 32'h40; jalr_sel = 1'b1; jalr_target = 32'h81;
    @(negedge clk);     chk("jalr_addr", imem_addr, 32'h80);
    clear_ctl();

    // Misaligned branch target 0x42 -> trap
    wait_exec("mis_a");
    pc_gen_out = 1'b1; target = 32'h42;
    @(negedge clk);
    chk("mis_pc",    pc,                32'h100);
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
    chk("mis_req",   {31'b0, imem_req}, 32'h1);
    clear_ctl();
    @(negedge clk);
    chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
    chk("mis_exec_pc",   pc,                32'h100);

    // Misaligned JALR target 0x103 -> 0x102 -> trap
    jalr_sel = 1'b1; jalr_target = 32'h103;
    @(negedge clk);
    chk("mis_jalr_pulse", {31'b0, misalign}, 32'h1);
    chk("mis_jalr_pc",    pc,                32'h100);
    clear_ctl();

    // Memory wait: ack held low for three FETCH cycles
    wait_exec("wait_a");
    imem_ack = 1'b0;
    req_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (imem_req) req_cnt++;
    end
    imem_ack = 1'b1;
    @(negedge clk);
    chk("wait_req_cycles", req_cnt, 4);
    chk("wait_exec_valid", {31'b0, instr_valid}, 32'h1);
    chk("wait_pc",         pc,                   32'h104);

    // Stall for two EXEC cycles; halt_req under stall must not halt
    stall = 1'b1; halt_req = 1'b1;
    val_cnt = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (instr_valid) val_cnt++;
      chk("stall_pc", pc, 32'h104);
    end
    clear_ctl();
    @(negedge clk);
    if (instr_valid) val_cnt++;
    chk("stall_valid_cycles", val_cnt, 3);
    chk("stall_next_pc",      pc,      32'h108);

    // Wrap-around at 0xFFFFFFFC
    wait_exec("wrap_a");
    pc_gen_out = 1'b1; target = 32'hFFFF_FFFC;
    @(negedge clk);
    clear_ctl();
    wait_exec("wrap_b");
    chk("wrap_pc",    pc,       32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    @(negedge clk);
    chk("wrap_addr",  imem_addr, 32'h0);
    wait_exec("wrap_c");
    wait_exec("halt_a");
    chk("halt_exec_pc", pc, 32'h4);

    // Halt: absorbing, inputs ignored
    halt_req = 1'b1;
    @(negedge clk);
    clear_ctl();
    pc_gen_out = 1'b1; target = 32'h80; jalr_sel = 1'b1; jalr_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      chk("halt_flag", {31'b0, halted},   32'h1);
      chk("halt_req0", {31'b0, imem_req}, 32'h0);
      chk("halt_pc",   pc,                32'h4);
      @(negedge clk);
    end
    clear_ctl();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("halt_rst_pc",     pc,               RESET_PC);
    chk("halt_rst_halted", {31'b0, halted},  32'h0);

    // Reset mid-FETCH with a late ack
    imem_ack = 1'b0;
    @(negedge clk);
    chk("mid_fetch_req", {31'b0, imem_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    chk("mid_no_exec", {31'b0, instr_valid}, 32'h0);
    chk("mid_refetch", {31'b0, imem_req},    32'h1);
    chk("mid_pc",      pc,                   RESET_PC);
    @(negedge clk);
    chk("mid_exec",    {31'b0, instr_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
